// File: rtl/compose_eval_fsm_pkg.sv
// rtl/compose_eval_fsm_pkg.sv - shared state and compare-mode encodings for compose_eval_fsm
// Purpose: state constants INITIAL..HOLD (0..4) and unsigned compare modes.
// Ports: none (package).
package compose_eval_pkg;

  typedef enum logic [2:0] {
    INITIAL = 3'd0,
    IDLE    = 3'd1,
    COMPOSE = 3'd2,
    COMPARE = 3'd3,
    HOLD    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_EQ  = 2'd0,
    MODE_NE  = 2'd1,
    MODE_LTU = 2'd2,
    MODE_GEU = 2'd3
  } mode_e;

endpackage

// File: rtl/compose_eval_fsm_if.sv
// rtl/compose_eval_fsm_if.sv - operand/result handshake bundle for compose_eval_fsm
// Purpose: groups the operand channel, result channel and debug status.
// Ports (signals):
//   in_valid/in_ready, in_a, in_b, in_ref, in_mode : operand channel
//   out_valid/out_ready, out1, out_carry           : result channel
//   busy, fsm_state                                : status
// Modports: master = operand producer / result consumer, slave = evaluation core.
interface compose_eval_fsm_if #(
  parameter int WIDTH   = 32,
  parameter int STATE_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [WIDTH-1:0]   in_ref;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out1;
  logic               out_carry;
  logic               busy;
  logic [STATE_W-1:0] fsm_state;

  modport master (
    output in_valid, in_a, in_b, in_ref, in_mode, out_ready,
    input  in_ready, out_valid, out1, out_carry, busy, fsm_state
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ref, in_mode, out_ready,
    output in_ready, out_valid, out1, out_carry, busy, fsm_state
  );
endinterface

// File: rtl/compose_eval_fsm_cmp.sv
// rtl/compose_eval_fsm_cmp.sv - unsigned compare of accumulator against reference
// Purpose: purely combinational condition evaluation.
// Ports:
//   acc     in  WIDTH  accumulated value
//   ref_val in  WIDTH  comparison reference
//   mode    in  2      EQ / NE / LTU / GEU
//   cond    out 1      comparison result
module compose_cmp
  import compose_eval_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] ref_val,
  input  mode_e            mode,
  output logic             cond
);

  always_comb begin
    cond = 1'b0;
    case (mode)
      MODE_EQ:  cond = (acc == ref_val);
      MODE_NE:  cond = (acc != ref_val);
      MODE_LTU: cond = (acc <  ref_val);
      MODE_GEU: cond = (acc >= ref_val);
      default:  cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/compose_eval_fsm.sv
// rtl/compose_eval_fsm.sv - iterative acc = a + REPEAT*b evaluation core with compare and held result
// Purpose: accepts an operand set, adds b REPEAT times (one add per cycle),
//   compares against ref and holds THEN_VAL/ELSE_VAL until the consumer takes it.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    slave modport of compose_eval_fsm_if (operand, result, status)
module compose_eval_fsm
  import compose_eval_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STATE_W  = 8,
  parameter int REPEAT   = 1,
  parameter int THEN_VAL = 1,
  parameter int ELSE_VAL = 2
) (
  input  logic                clk,
  input  logic                reset,
  compose_eval_fsm_if.slave   bus
);

  if (REPEAT < 1 || STATE_W < 3) begin : g_param_check
    $error("compose_eval_fsm: REPEAT must be >= 1 and STATE_W must be >= 3");
  end

  // iter only has to reach REPEAT-1; keep at least one bit for REPEAT==1.
  localparam int                IW     = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [IW-1:0]     LAST   = IW'(REPEAT - 1);
  localparam logic [WIDTH-1:0]  THEN_W = WIDTH'(THEN_VAL);
  localparam logic [WIDTH-1:0]  ELSE_W = WIDTH'(ELSE_VAL);

  state_e           state;
  state_e           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] ref_q;
  mode_e            mode_q;
  logic [IW-1:0]    iter;
  logic [WIDTH-1:0] out1_q;
  logic             out_valid_q;
  logic             out_carry_q;
  logic             cond;
  logic [WIDTH:0]   sum;

  // Extra top bit is the carry-out of the WIDTH-bit add.
  assign sum = {1'b0, acc} + {1'b0, b_q};

  compose_cmp #(.WIDTH(WIDTH)) u_cmp (
    .acc     (acc),
    .ref_val (ref_q),
    .mode    (mode_q),
    .cond    (cond)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INITIAL;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = INITIAL;
    case (state)
      INITIAL: state_nx = IDLE;
      IDLE:    state_nx = bus.in_valid ? COMPOSE : IDLE;
      COMPOSE: state_nx = (iter == LAST) ? COMPARE : COMPOSE;
      COMPARE: state_nx = HOLD;
      HOLD:    state_nx = bus.out_ready ? IDLE : HOLD;
      default: state_nx = INITIAL;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == COMPOSE) || (state == COMPARE) || (state == HOLD);
    bus.fsm_state = STATE_W'(state);
    bus.out1      = out1_q;
    bus.out_valid = out_valid_q;
    bus.out_carry = out_carry_q;
  end

  // Datapath: operand capture, accumulation and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      iter        <= '0;
      b_q         <= '0;
      ref_q       <= '0;
      mode_q      <= MODE_EQ;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
      out_carry_q <= 1'b0;
    end else begin
      case (state)
        INITIAL: begin
          out1_q <= '0;
        end
        IDLE: begin
          if (bus.in_valid) begin
            acc         <= bus.in_a;
            b_q         <= bus.in_b;
            ref_q       <= bus.in_ref;
            mode_q      <= mode_e'(bus.in_mode);
            iter        <= '0;
            out_carry_q <= 1'b0;
          end
        end
        COMPOSE: begin
          acc         <= sum[WIDTH-1:0];
          out_carry_q <= out_carry_q | sum[WIDTH];
          iter        <= iter + IW'(1);
        end
        COMPARE: begin
          out1_q      <= cond ? THEN_W : ELSE_W;
          out_valid_q <= 1'b1;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compose_eval_fsm.sv
// tb/tb_compose_eval_fsm.sv - self-checking bench for compose_eval_fsm at REPEAT 1, 3 and 4
module tb_compose_eval_fsm;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       [3];
  logic         in_valid  [3];
  logic [W-1:0] in_a      [3];
  logic [W-1:0] in_b      [3];
  logic [W-1:0] in_ref    [3];
  logic [1:0]   in_mode   [3];
  logic         out_ready [3];

  wire          in_ready_w  [3];
  wire          out_valid_w [3];
  wire          carry_w     [3];
  wire          busy_w      [3];
  wire [W-1:0]  out1_w      [3];
  wire [7:0]    st_w        [3];

  int errors = 0;
  int checks = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int RP = (k == 0) ? 1 : (k == 1) ? 3 : 4;
    compose_eval_fsm_if #(.WIDTH(W), .STATE_W(8)) bus ();
    compose_eval_fsm #(
      .WIDTH(W), .STATE_W(8), .REPEAT(RP), .THEN_VAL(1), .ELSE_VAL(2)
    ) dut (
      .clk   (clk),
      .reset (rst[k]),
      .bus   (bus.slave)
    );
    assign bus.in_valid   = in_valid[k];
    assign bus.in_a       = in_a[k];
    assign bus.in_b       = in_b[k];
    assign bus.in_ref     = in_ref[k];
    assign bus.in_mode    = in_mode[k];
    assign bus.out_ready  = out_ready[k];
    assign in_ready_w[k]  = bus.in_ready;
    assign out_valid_w[k] = bus.out_valid;
    assign carry_w[k]     = bus.out_carry;
    assign busy_w[k]      = bus.busy;
    assign out1_w[k]      = bus.out1;
    assign st_w[k]        = bus.fsm_state;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the exact sum a + r*b; wrap happened at some step iff it reaches 2^32.
  function automatic void model(input int r, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] rf, input logic [1:0] m,
                                output logic [31:0] o1, output logic cy);
    logic [63:0] total;
    logic [31:0] acc;
    bit          c;
    total = 64'(a) + 64'(r) * 64'(b);
    acc   = total[31:0];
    cy    = (total >= 64'h1_0000_0000);
    case (m)
      2'd0:    c = (acc == rf);
      2'd1:    c = (acc != rf);
      2'd2:    c = (acc < rf);
      default: c = (acc >= rf);
    endcase
    o1 = c ? 32'd1 : 32'd2;
  endfunction

  task automatic run_op(int k, int r, logic [31:0] a, logic [31:0] b, logic [31:0] rf,
                        logic [1:0] m, int hold, string tag);
    logic [31:0] eo;
    logic        ec;
    int          n;
    model(r, a, b, rf, m, eo, ec);
    n = 0;
    while (!in_ready_w[k] && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " in_ready_before"}, 64'(in_ready_w[k]), 64'd1);
    in_valid[k] = 1'b1;
    in_a[k]     = a;
    in_b[k]     = b;
    in_ref[k]   = rf;
    in_mode[k]  = m;
    tick();
    in_valid[k] = 1'b0;
    in_a[k]     = $urandom;
    in_b[k]     = $urandom;
    n = 0;
    while (!out_valid_w[k] && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(r + 1));
    chk({tag, " out1"}, 64'(out1_w[k]), 64'(eo));
    chk({tag, " carry"}, 64'(carry_w[k]), 64'(ec));
    chk({tag, " busy_hold"}, 64'(busy_w[k]), 64'd1);
    chk({tag, " state_hold"}, 64'(st_w[k]), 64'd4);
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'b1;
      in_a[k]     = $urandom;
      in_b[k]     = $urandom;
      in_ref[k]   = $urandom;
      in_mode[k]  = 2'($urandom_range(0, 3));
      tick();
      in_valid[k] = 1'b0;
      chk({tag, " hold_out1"}, 64'(out1_w[k]), 64'(eo));
      chk({tag, " hold_valid"}, 64'(out_valid_w[k]), 64'd1);
      chk({tag, " hold_carry"}, 64'(carry_w[k]), 64'(ec));
      chk({tag, " hold_in_ready"}, 64'(in_ready_w[k]), 64'd0);
    end
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    chk({tag, " release_valid"}, 64'(out_valid_w[k]), 64'd0);
    chk({tag, " release_state"}, 64'(st_w[k]), 64'd1);
    chk({tag, " release_in_ready"}, 64'(in_ready_w[k]), 64'd1);
  endtask

  initial begin
    logic [31:0] a, b, rf;
    logic [1:0]  m;
    int          r;
    bit          seen;

    for (int k = 0; k < 3; k++) begin
      rst[k]       = 1'b1;
      in_valid[k]  = 1'b0;
      in_a[k]      = '0;
      in_b[k]      = '0;
      in_ref[k]    = '0;
      in_mode[k]   = '0;
      out_ready[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("reset state", 64'(st_w[k]), 64'd0);
      chk("reset out1", 64'(out1_w[k]), 64'd0);
      chk("reset out_valid", 64'(out_valid_w[k]), 64'd0);
      chk("reset carry", 64'(carry_w[k]), 64'd0);
      chk("reset in_ready", 64'(in_ready_w[k]), 64'd0);
      chk("reset busy", 64'(busy_w[k]), 64'd0);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("post reset state", 64'(st_w[k]), 64'd1);
      chk("post reset in_ready", 64'(in_ready_w[k]), 64'd1);
    end

    run_op(0, 1, 32'd1, 32'd50, 32'd0, 2'd0, 0, "r1 eq else");
    run_op(0, 1, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 0, "r1 wrap");
    run_op(1, 3, 32'd1, 32'd50, 32'd151, 2'd0, 0, "r3 eq then");
    run_op(1, 3, 32'd1, 32'd50, 32'd200, 2'd2, 0, "r3 ltu");
    run_op(1, 3, 32'd1, 32'd50, 32'd200, 2'd3, 5, "r3 geu backpressure");

    for (int it = 0; it < 24; it++) begin
      int k;
      k  = it % 3;
      r  = (k == 0) ? 1 : (k == 1) ? 3 : 4;
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
      m  = 2'($urandom_range(0, 3));
      rf = ($urandom_range(0, 1) == 1) ? 32'(64'(a) + 64'(r) * 64'(b)) : $urandom;
      run_op(k, r, a, b, rf, m, $urandom_range(0, 2), "random");
    end

    // Abort on instance with REPEAT=4 during its second COMPOSE cycle.
    in_valid[2] = 1'b1;
    in_a[2]     = 32'd7;
    in_b[2]     = 32'd9;
    in_ref[2]   = 32'd0;
    in_mode[2]  = 2'd1;
    tick();
    in_valid[2] = 1'b0;
    tick();
    chk("abort in compose", 64'(st_w[2]), 64'd2);
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    chk("abort state", 64'(st_w[2]), 64'd0);
    chk("abort out1", 64'(out1_w[2]), 64'd0);
    chk("abort out_valid", 64'(out_valid_w[2]), 64'd0);
    chk("abort in_ready", 64'(in_ready_w[2]), 64'd0);
    seen = 1'b0;
    tick();
    chk("abort then idle", 64'(st_w[2]), 64'd1);
    chk("abort idle in_ready", 64'(in_ready_w[2]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (out_valid_w[2]) seen = 1'b1;
      tick();
    end
    chk("abort no out_valid", 64'(seen), 64'd0);
    run_op(2, 4, 32'd10, 32'd5, 32'd30, 2'd0, 1, "after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
